// File: rtl/nmos_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nmos_pkg : shared modes and helpers for NMOS wide cells     rev 1.0  |
// +----------------------------------------------------------------------+
package nmos_pkg;

   typedef enum logic {
      PRIO   = 1'b0,
      STRICT = 1'b1
   } famux_mode_e;

   // True when two or more bits are set; clearing the lowest set bit must leave something.
   function automatic logic onehot_multi(input logic [15:0] v);
      return |(v & (v - 16'd1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/nmos_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nmos_prio_enc : N-input highest-index priority encoder      rev 1.0  |
// +----------------------------------------------------------------------+
module nmos_prio_enc
   import nmos_pkg::*;
#(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o,
   output logic             multi_o
);

   logic [15:0] w_req16;

   always_comb begin
      w_req16 = 16'(req_i);
      any_o   = |req_i;
      multi_o = onehot_multi(w_req16);
      idx_o   = '0;
      // Ascending scan, so the last match (highest index) wins.
      for (int k = 0; k < N; k++) begin
         if (req_i[k]) begin
            idx_o = k[IDX_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/nmos_famux_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nmos_famux_n : registered N-way force-mux with hold-age     rev 1.0  |
// +----------------------------------------------------------------------+
module nmos_famux_n
   import nmos_pkg::*;
#(
   parameter int             W       = 8,
   parameter int             N       = 3,
   parameter logic [W-1:0]   RST_VAL = '0,
   parameter int             AGE_W   = 8,
   parameter int             STRICT  = 0
) (
   input  logic               main_clk,
   input  logic               main_rst,
   input  logic [N*W-1:0]     d,
   input  logic [N-1:0]       sel,
   input  logic [W-1:0]       ff,
   output logic [W-1:0]       q,
   output logic               q_vld,
   output logic               q_chg,
   output logic               conflict,
   output logic [AGE_W-1:0]   age
);

   localparam int               c_IDX_W   = $clog2(N);
   localparam famux_mode_e      c_MODE    = (STRICT != 0) ? nmos_pkg::STRICT : nmos_pkg::PRIO;
   localparam logic [AGE_W-1:0] c_AGE_MAX = {AGE_W{1'b1}};

   logic [c_IDX_W-1:0] w_idx;
   logic               w_any;
   logic               w_multi;
   logic               w_load;
   logic [W-1:0]       w_val;

   logic [W-1:0]       q_d, q_q;
   logic               vld_d, vld_q;
   logic               chg_d, chg_q;
   logic               conf_d, conf_q;
   logic [AGE_W-1:0]   age_d, age_q;

   nmos_prio_enc #(
      .N     (N),
      .IDX_W (c_IDX_W)
   ) u_enc (
      .req_i   (sel),
      .idx_o   (w_idx),
      .any_o   (w_any),
      .multi_o (w_multi)
   );

   always_comb begin
      // In strict mode a multi-select cycle behaves exactly like an idle one.
      w_load = w_any && !(w_multi && (c_MODE == nmos_pkg::STRICT));
      w_val  = d[w_idx*W +: W] | ff;

      q_d    = w_load ? w_val : q_q;
      vld_d  = vld_q | w_load;
      chg_d  = w_load && (w_val != q_q);
      conf_d = w_multi;
      if (w_load) begin
         age_d = '0;
      end else if (age_q == c_AGE_MAX) begin
         age_d = age_q;
      end else begin
         age_d = age_q + 1'b1;
      end
   end

   always_ff @(posedge main_clk or posedge main_rst) begin
      if (main_rst) begin
         q_q    <= RST_VAL;
         vld_q  <= 1'b0;
         chg_q  <= 1'b0;
         conf_q <= 1'b0;
         age_q  <= '0;
      end else begin
         q_q    <= q_d;
         vld_q  <= vld_d;
         chg_q  <= chg_d;
         conf_q <= conf_d;
         age_q  <= age_d;
      end
   end

   assign q        = q_q;
   assign q_vld    = vld_q;
   assign q_chg    = chg_q;
   assign conflict = conf_q;
   assign age      = age_q;

endmodule
`default_nettype wire

// File: tb/tb_nmos_famux_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nmos_famux_n : scoreboard bench, PRIO and STRICT instances rev 1.0|
// +----------------------------------------------------------------------+
module tb_nmos_famux_n;

   typedef struct {
      logic [7:0] q;
      logic       vld;
      logic       chg;
      logic       conf;
      logic [3:0] age;
   } exp_t;

   logic        main_clk = 1'b0;
   logic        main_rst = 1'b1;
   logic [23:0] d        = '0;
   logic [2:0]  sel      = '0;
   logic [7:0]  ff       = '0;

   logic [7:0] q0, q1;
   logic       vld0, vld1, chg0, chg1, conf0, conf1;
   logic [3:0] age0, age1;

   exp_t exq0[$];
   exp_t exq1[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 main_clk = ~main_clk;

   nmos_famux_n #(.W(8), .N(3), .RST_VAL(8'hA5), .AGE_W(4), .STRICT(0)) dut_prio (
      .main_clk (main_clk), .main_rst (main_rst), .d (d), .sel (sel), .ff (ff),
      .q (q0), .q_vld (vld0), .q_chg (chg0), .conflict (conf0), .age (age0)
   );

   nmos_famux_n #(.W(8), .N(3), .RST_VAL(8'hA5), .AGE_W(4), .STRICT(1)) dut_strict (
      .main_clk (main_clk), .main_rst (main_rst), .d (d), .sel (sel), .ff (ff),
      .q (q1), .q_vld (vld1), .q_chg (chg1), .conflict (conf1), .age (age1)
   );

   function automatic exp_t mk(input logic [7:0] eq, input logic ev, input logic ec,
                               input logic ef, input logic [3:0] ea);
      exp_t e;
      e.q = eq; e.vld = ev; e.chg = ec; e.conf = ef; e.age = ea;
      return e;
   endfunction

   task automatic compare(input string name, input logic [7:0] aq, input logic av,
                          input logic ac, input logic af, input logic [3:0] aa, input exp_t e);
      n_cmp++;
      if (aq !== e.q || av !== e.vld || ac !== e.chg || af !== e.conf || aa !== e.age) begin
         n_bad++;
         $display("FAIL %s @%0t: got q=%h vld=%b chg=%b conf=%b age=%0d, want q=%h vld=%b chg=%b conf=%b age=%0d",
                  name, $time, aq, av, ac, af, aa, e.q, e.vld, e.chg, e.conf, e.age);
      end
   endtask

   // Drive one cycle of stimulus and record the response expected after the next edge.
   task automatic step(input logic [2:0] s, input logic [23:0] dd, input logic [7:0] f,
                       input exp_t e0, input exp_t e1);
      @(negedge main_clk);
      sel = s; d = dd; ff = f;
      exq0.push_back(e0);
      exq1.push_back(e1);
   endtask

   task automatic check_reset(input string name);
      compare({name, "_prio"},   q0, vld0, chg0, conf0, age0, mk(8'hA5, 0, 0, 0, 0));
      compare({name, "_strict"}, q1, vld1, chg1, conf1, age1, mk(8'hA5, 0, 0, 0, 0));
   endtask

   // Monitor: outputs are registered with no handshake, so every pushed expectation
   // is due just after the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge main_clk);
         #2;
         if (exq0.size() > 0) begin
            e = exq0.pop_front();
            compare("prio", q0, vld0, chg0, conf0, age0, e);
         end
         if (exq1.size() > 0) begin
            e = exq1.pop_front();
            compare("strict", q1, vld1, chg1, conf1, age1, e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, queues %0d/%0d", exq0.size(), exq1.size());
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_reset("reset_initial");
      @(negedge main_clk);
      main_rst = 1'b0;

      // Single select with force: 0x12 | 0x80.
      step(3'b010, 24'h00_12_00, 8'h80, mk(8'h92, 1, 1, 0, 0), mk(8'h92, 1, 1, 0, 0));
      step(3'b001, 24'h00_00_33, 8'h00, mk(8'h33, 1, 1, 0, 0), mk(8'h33, 1, 1, 0, 0));
      // Same-value reload from another channel: age clears, no change pulse.
      step(3'b100, 24'h33_00_00, 8'h00, mk(8'h33, 1, 0, 0, 0), mk(8'h33, 1, 0, 0, 0));
      // Multi-select: PRIO loads channel 2, STRICT holds and ages.
      step(3'b101, 24'h04_00_01, 8'h00, mk(8'h04, 1, 1, 1, 0), mk(8'h33, 1, 0, 1, 1));
      step(3'b000, 24'h04_00_01, 8'hFF, mk(8'h04, 1, 0, 0, 1), mk(8'h33, 1, 0, 0, 2));
      // Back-to-back loads of distinct values.
      step(3'b001, 24'h00_00_01, 8'h00, mk(8'h01, 1, 1, 0, 0), mk(8'h01, 1, 1, 0, 0));
      step(3'b010, 24'h00_02_00, 8'h00, mk(8'h02, 1, 1, 0, 0), mk(8'h02, 1, 1, 0, 0));
      // Idle with a live force term and junk data: hold, age saturates at 15.
      for (int i = 1; i <= 20; i++) begin
         step(3'b000, 24'hFF_FF_FF, 8'hFF,
              mk(8'h02, 1, 0, 0, (i > 15) ? 4'd15 : 4'(i)),
              mk(8'h02, 1, 0, 0, (i > 15) ? 4'd15 : 4'(i)));
      end

      // Asynchronous reset mid-cycle takes effect without an edge.
      @(posedge main_clk);
      #3;
      main_rst = 1'b1;
      #1;
      check_reset("reset_async");

      // First edge after release performs a normal load.
      @(negedge main_clk);
      main_rst = 1'b0;
      sel = 3'b001; d = 24'h00_00_5A; ff = 8'h01;
      exq0.push_back(mk(8'h5B, 1, 1, 0, 0));
      exq1.push_back(mk(8'h5B, 1, 1, 0, 0));
      @(negedge main_clk);
      sel = 3'b000;

      for (int i = 0; i < 10 && (exq0.size() > 0 || exq1.size() > 0); i++) begin
         @(posedge main_clk);
      end
      #3;
      n_cmp++;
      if (exq0.size() != 0 || exq1.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", exq0.size(), exq1.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
